// File: rtl/axi4_slave_write_responder.sv
// AXI4 write-channel slave: one outstanding AW/W/B transaction into an internal word memory.
// Optional wlast consistency check is compiled in when AXI4_WLAST_CHECK_EN is defined.
module axi4_slave_write_responder #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned MEM_WORDS  = 1024
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [ID_WIDTH-1:0]          awid,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic [LEN_WIDTH-1:0]         awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_WIDTH-1:0]          bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_WIDTH  = ADDR_WIDTH - 2;
  localparam int unsigned MEM_AW     = $clog2(MEM_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]  id;
    logic [LEN_WIDTH-1:0] len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } aw_cmd_t;

  state_t                state, state_nxt;
  aw_cmd_t               cmd_q, cmd_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [LEN_WIDTH-1:0]  beat_cnt, beat_nxt;
  logic                  bad_cmd_q, bad_cmd_nxt;
  logic                  decerr_q, decerr_nxt;
  logic                  slverr_any;
  logic                  awready_nxt, wready_nxt, bvalid_nxt;
  logic [ID_WIDTH-1:0]   bid_nxt;
  logic [1:0]            bresp_nxt;
  logic                  mem_we;
  logic [IDX_WIDTH-1:0]  idx;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] step;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

`ifdef AXI4_WLAST_CHECK_EN
  logic wlast_err_q, wlast_err_nxt;
`else
  logic unused_wlast;
  assign unused_wlast = wlast;
`endif

  assign idx      = addr_q[ADDR_WIDTH-1:2];
  assign in_range = 32'(idx) < MEM_WORDS;
  assign step     = ADDR_WIDTH'(1) << cmd_q.size;

  // State, handshake outputs and per-transaction context
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= RESP_OKAY;
      cmd_q     <= '0;
      addr_q    <= '0;
      beat_cnt  <= '0;
      bad_cmd_q <= 1'b0;
      decerr_q  <= 1'b0;
`ifdef AXI4_WLAST_CHECK_EN
      wlast_err_q <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      awready   <= awready_nxt;
      wready    <= wready_nxt;
      bvalid    <= bvalid_nxt;
      bid       <= bid_nxt;
      bresp     <= bresp_nxt;
      cmd_q     <= cmd_nxt;
      addr_q    <= addr_nxt;
      beat_cnt  <= beat_nxt;
      bad_cmd_q <= bad_cmd_nxt;
      decerr_q  <= decerr_nxt;
`ifdef AXI4_WLAST_CHECK_EN
      wlast_err_q <= wlast_err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    awready_nxt = 1'b0;
    wready_nxt  = 1'b0;
    bvalid_nxt  = 1'b0;
    bid_nxt     = bid;
    bresp_nxt   = bresp;
    cmd_nxt     = cmd_q;
    addr_nxt    = addr_q;
    beat_nxt    = beat_cnt;
    bad_cmd_nxt = bad_cmd_q;
    decerr_nxt  = decerr_q;
    mem_we      = 1'b0;
    slverr_any  = 1'b0;
`ifdef AXI4_WLAST_CHECK_EN
    wlast_err_nxt = wlast_err_q;
`endif
    unique case (state)
      IDLE: begin
        awready_nxt = 1'b1;
        if (awvalid && awready) begin
          cmd_nxt     = '{id: awid, len: awlen, size: awsize, burst: awburst};
          addr_nxt    = awaddr;
          beat_nxt    = '0;
          bad_cmd_nxt = awburst[1] || (awsize > 3'd2);
          decerr_nxt  = 1'b0;
`ifdef AXI4_WLAST_CHECK_EN
          wlast_err_nxt = 1'b0;
`endif
          state_nxt   = DATA;
          awready_nxt = 1'b0;
          wready_nxt  = 1'b1;
        end
      end
      DATA: begin
        wready_nxt = 1'b1;
        if (wvalid && wready) begin
          // Out-of-range beats are dropped; unsupported commands drop every beat
          if (!in_range) decerr_nxt = 1'b1;
          else if (!bad_cmd_q) mem_we = 1'b1;
`ifdef AXI4_WLAST_CHECK_EN
          if (wlast != (beat_cnt == cmd_q.len)) wlast_err_nxt = 1'b1;
`endif
          if (cmd_q.burst == 2'b01) addr_nxt = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;
          beat_nxt = beat_cnt + LEN_WIDTH'(1);
          if (beat_cnt == cmd_q.len) begin
`ifdef AXI4_WLAST_CHECK_EN
            slverr_any = bad_cmd_q || wlast_err_nxt;
`else
            slverr_any = bad_cmd_q;
`endif
            state_nxt  = RESP;
            wready_nxt = 1'b0;
            bvalid_nxt = 1'b1;
            bid_nxt    = cmd_q.id;
            bresp_nxt  = decerr_nxt ? RESP_DECERR : (slverr_any ? RESP_SLVERR : RESP_OKAY);
          end
        end
      end
      RESP: begin
        bvalid_nxt = 1'b1;
        if (bvalid && bready) begin
          state_nxt   = IDLE;
          bvalid_nxt  = 1'b0;
          awready_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte-strobed memory write; contents survive reset
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb[i]) mem[idx[MEM_AW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Directed + randomized bench for axi4_slave_write_responder against a byte-level memory model.
module tb_axi4_slave_write_responder;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [7:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_word  [1024];
  logic [31:0] ref_known [1024];
  logic [31:0] beat_data [256];
  logic [3:0]  beat_strb [256];

  axi4_slave_write_responder dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: walk the beat addresses with plain arithmetic, apply strobes byte-wise
  task automatic model_txn(input int addr, input int len, input int size, input int burst,
                           input int nbeats, output logic [1:0] resp);
    int a  = addr;
    int nb = 1 << size;
    bit slv = (burst > 1) || (size > 2);
    bit dec = 0;
    for (int b = 0; b < nbeats; b++) begin
      int w = a / 4;
      if (w >= 1024) dec = 1;
      else if (!slv) begin
        for (int i = 0; i < 4; i++) begin
          if (beat_strb[b][i]) begin
            ref_word[w][8*i +: 8]  = beat_data[b][8*i +: 8];
            ref_known[w][8*i +: 8] = 8'hFF;
          end
        end
      end
      if (burst == 1) a = ((a / nb) * nb + nb) % 65536;
    end
    resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    if (len < 0) resp = 2'b00;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int cnt = 0;
    check("wready_idle", 32'(wready), 32'd0);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!awready && cnt < 50) begin @(posedge aclk); #1; cnt++; end
    check("aw_wait", 32'(awready), 32'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    check("awready_after_aw", 32'(awready), 32'd0);
    check("wready_after_aw", 32'(wready), 32'd1);
  endtask

  task automatic send_beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                           input bit gap);
    int cnt = 0;
    if (gap) begin wvalid = 1'b0; @(posedge aclk); #1; end
    wvalid = 1'b1; wdata = data; wstrb = strb; wlast = last;
    while (!wready && cnt < 50) begin @(posedge aclk); #1; cnt++; end
    check("w_wait", 32'(wready), 32'd1);
    @(posedge aclk); #1;
    wvalid = 1'b0;
  endtask

  task automatic finish_b(input logic [7:0] id, input logic [1:0] resp, input int delay);
    check("bvalid_latency", 32'(bvalid), 32'd1);
    check("wready_in_resp", 32'(wready), 32'd0);
    check("bid", 32'(bid), 32'(id));
    check("bresp", 32'(bresp), 32'(resp));
    for (int k = 0; k < delay; k++) begin
      @(posedge aclk); #1;
      check("bvalid_hold", 32'(bvalid), 32'd1);
      check("bid_hold", 32'(bid), 32'(id));
      check("bresp_hold", 32'(bresp), 32'(resp));
      check("awready_hold", 32'(awready), 32'd0);
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("bvalid_drop", 32'(bvalid), 32'd0);
    check("awready_back", 32'(awready), 32'd1);
  endtask

  task automatic run_txn(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit gap,
                         input int delay);
    logic [1:0] resp;
    model_txn(int'(addr), int'(len), int'(size), int'(burst), int'(len) + 1, resp);
    send_aw(id, addr, len, size, burst);
    for (int b = 0; b <= int'(len); b++)
      send_beat(beat_data[b], beat_strb[b], b == int'(len), gap && b > 0);
    finish_b(id, resp, delay);
  endtask

  task automatic check_word(input string tag, input int w, input logic [31:0] mask,
                            input logic [31:0] exp);
    dbg_addr = 10'(w); #1;
    check(tag, dbg_rdata & mask, exp & mask);
  endtask

  task automatic check_mem();
    for (int w = 0; w < 1024; w++)
      if (ref_known[w] != 32'd0) check_word("mem_model", w, ref_known[w], ref_word[w]);
  endtask

  initial begin
    logic [1:0] r;
    for (int w = 0; w < 1024; w++) begin ref_word[w] = '0; ref_known[w] = '0; end
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; dbg_addr = '0;

    aresetn = 1'b0;
    #3;
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("awready_after_rst", 32'(awready), 32'd1);

    // Single write
    beat_data[0] = 32'hDEADBEEF; beat_strb[0] = 4'hF;
    run_txn(8'h05, 16'h0010, 8'd0, 3'd2, 2'b01, 1'b0, 0);
    check_word("single_mem4", 4, 32'hFFFFFFFF, 32'hDEADBEEF);

    // INCR burst, then the same with wvalid gaps
    for (int rep = 0; rep < 2; rep++) begin
      for (int b = 0; b < 4; b++) begin beat_data[b] = 32'h11111111 * (b + 1); beat_strb[b] = 4'hF; end
      run_txn(8'h10 + 8'(rep), 16'h0020, 8'd3, 3'd2, 2'b01, rep == 1, 0);
      for (int b = 0; b < 4; b++) check_word("incr_mem", 8 + b, 32'hFFFFFFFF, 32'h11111111 * (b + 1));
    end

    // FIXED burst with partial strobes
    beat_data[0] = 32'hAABBCCDD; beat_strb[0] = 4'hF;
    beat_data[1] = 32'h00001122; beat_strb[1] = 4'h3;
    run_txn(8'h20, 16'h0040, 8'd1, 3'd2, 2'b00, 1'b0, 0);
    check_word("fixed_mem16", 16, 32'hFFFFFFFF, 32'hAABB1122);

    // Unaligned halfword INCR
    beat_data[0] = 32'hFFFFFFFF; beat_strb[0] = 4'h8;
    beat_data[1] = 32'hFFFFFFFF; beat_strb[1] = 4'h1;
    run_txn(8'h21, 16'h0003, 8'd1, 3'd1, 2'b01, 1'b0, 0);
    check_word("unal_mem0", 0, 32'hFF000000, 32'hFF000000);
    check_word("unal_mem1", 1, 32'h000000FF, 32'h000000FF);

    // Reserved burst type over mem[4]: SLVERR, nothing written
    beat_data[0] = 32'h01234567; beat_strb[0] = 4'hF;
    beat_data[1] = 32'h89ABCDEF; beat_strb[1] = 4'hF;
    run_txn(8'h30, 16'h0010, 8'd1, 3'd2, 2'b10, 1'b0, 0);
    check_word("slverr_mem4", 4, 32'hFFFFFFFF, 32'hDEADBEEF);

    // Out-of-range word 1024: DECERR, index must not alias to word 0
    beat_data[0] = 32'h00000000; beat_strb[0] = 4'hF;
    run_txn(8'h31, 16'h1000, 8'd0, 3'd2, 2'b01, 1'b0, 0);
    check_word("decerr_mem0", 0, 32'hFF000000, 32'hFF000000);

    // B backpressure
    beat_data[0] = 32'hCAFEF00D; beat_strb[0] = 4'hF;
    run_txn(8'h7E, 16'h0200, 8'd0, 3'd2, 2'b01, 1'b0, 5);

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      logic [15:0] a;
      logic [7:0]  l;
      logic [2:0]  s;
      logic [1:0]  bt;
      a  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 4095));
      l  = 8'($urandom_range(0, 7));
      s  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      bt = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      for (int b = 0; b <= int'(l); b++) begin
        beat_data[b] = $urandom;
        beat_strb[b] = 4'($urandom_range(0, 15));
      end
      run_txn(8'($urandom_range(0, 255)), a, l, s, bt, $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 3)));
    end
    check_mem();

    // Reset in the middle of a 4-beat burst
    for (int b = 0; b < 4; b++) begin beat_data[b] = 32'h5A5A0000 + 32'(b); beat_strb[b] = 4'hF; end
    model_txn(32'h0100, 3, 2, 1, 2, r);
    send_aw(8'h44, 16'h0100, 8'd3, 3'd2, 2'b01);
    send_beat(beat_data[0], beat_strb[0], 1'b0, 1'b0);
    send_beat(beat_data[1], beat_strb[1], 1'b0, 1'b0);
    #2 aresetn = 1'b0;
    #1;
    check("midrst_awready", 32'(awready), 32'd0);
    check("midrst_wready", 32'(wready), 32'd0);
    check("midrst_bvalid", 32'(bvalid), 32'd0);
    check("midrst_bid", 32'(bid), 32'd0);
    check("midrst_bresp", 32'(bresp), 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge aclk); #1;
      check("midrst_no_b", 32'(bvalid), 32'd0);
    end
    check_word("midrst_mem64", 64, 32'hFFFFFFFF, 32'h5A5A0000);
    check_word("midrst_mem65", 65, 32'hFFFFFFFF, 32'h5A5A0001);
    check_mem();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_slave_write_responder.md
Name: axi4_slave_write_responder

Overview:
AXI4 write-channel responder (slave end) for the AXI4 verification environment. Accepts one write transaction at a time on AW and W, stores the data with byte strobes into an internal word memory, and returns the response on B. Supported encodings: FIXED/INCR bursts and 1/2/4-byte sizes. A debug read port lets the bench check memory contents directly.

Parameters:
ADDR_WIDTH, 16, address bus width
DATA_WIDTH, 32, data bus width (fixed at 32; STRB = DATA_WIDTH/8)
ID_WIDTH, 8, AWID/BID width
LEN_WIDTH, 8, AWLEN width (burst length = awlen+1, max 256)
MEM_WORDS, 1024, internal memory depth in DATA_WIDTH words

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
awid  in  ID_WIDTH  write address ID
awaddr  in  ADDR_WIDTH  start byte address
awlen  in  LEN_WIDTH  beats minus one
awsize  in  3  bytes per beat = 1<<awsize
awburst  in  2  00 FIXED, 01 INCR, others unsupported
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wlast  in  1  last beat marker
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_WIDTH  response ID (= captured awid)
bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
bvalid  out  1  B valid
bready  in  1  B ready
dbg_addr  in  $clog2(MEM_WORDS)  debug word index
dbg_rdata  out  DATA_WIDTH  combinational memory read at dbg_addr

Behaviour:
- Reset (aresetn low, async): state IDLE; awready=0, wready=0, bvalid=0, bid=0, bresp=00; beat counter, address register, and error flags cleared. Memory contents are not reset.
- FSM states IDLE, DATA, RESP. All handshake outputs are registered.
  - IDLE: awready=1 from the first clock after reset release. AW handshake (awvalid&awready) captures awid, awaddr, awlen, awsize, awburst and clears beat_cnt. Next cycle: DATA, awready=0, wready=1.
  - DATA: wready=1. Each W handshake writes the beat, then beat_cnt++. On the handshake where beat_cnt==awlen: next cycle RESP, wready=0, bvalid=1. No W acceptance in IDLE/RESP.
  - RESP: bvalid, bid, and bresp held stable until bready. On handshake: next cycle IDLE, bvalid=0, awready=1.
- Latency: bvalid rises 1 cycle after the final W handshake. Minimum transaction = 1 AW cycle + (awlen+1) beat cycles + 1 B cycle.
- Write: word index = addr[ADDR_WIDTH-1:2]. For each i with wstrb[i]=1, mem[idx][8i+7:8i] <= wdata[8i+7:8i]. Strobes are applied as given and are not masked by size.
- Address update after each beat:
  - FIXED: unchanged.
  - INCR: addr = (addr & ~((1<<awsize)-1)) + (1<<awsize). The first beat may be unaligned; later beats are aligned.
  - Arithmetic is modulo 2^ADDR_WIDTH (wraps to 0). No 4KB-boundary check.
- Errors:
  - awburst in {10,11} or awsize>2 → SLVERR. All beats are accepted, no memory writes.
  - A beat with idx>=MEM_WORDS → DECERR for the transaction. That beat is not written; other in-range beats are written.
  - Errors are sticky per transaction and cleared on AW accept. Final bresp = DECERR if any DECERR, else SLVERR if any SLVERR, else OKAY.
- Without the optional feature, wlast is ignored and the burst end is determined solely by awlen.
- awvalid asserted outside IDLE is held off (awready=0). W data arriving before AW is not accepted (wready=0 in IDLE).
- Reset mid-burst: transaction abandoned, no B issued; memory writes already completed remain.

Optional Feature:
Macro AXI4_WLAST_CHECK_EN.
- Defined: a beat with wlast=1 where beat_cnt!=awlen, or wlast=0 where beat_cnt==awlen, sets the SLVERR flag. Data is still written, and burst length still follows awlen. DECERR keeps priority.
- Undefined: wlast unused, with no added logic.

Test Plan:
- Single write: AW id=0x05 addr=0x0010 len=0 size=2 INCR; W data=0xDEADBEEF strb=F, bready=1 → mem[4]=0xDEADBEEF, bid=0x05, bresp=00, bvalid 1 cycle after the W handshake.
- INCR burst: addr=0x0020 len=3 size=2, data 0x11111111..0x44444444 → mem[8..11] hold those values in order, bresp=00. Repeat with wvalid toggling every other cycle → same result.
- FIXED burst + strobes: addr=0x0040 len=1 size=2 FIXED; beat0 0xAABBCCDD strb=F, beat1 0x00001122 strb=3 → mem[16]=0xAABB1122.
- Unaligned INCR size=1: addr=0x0003 len=1, data 0xFFFFFFFF strb=8 then strb=1 → beat addresses 0x0003 and 0x0004; mem[0][31:24]=FF, mem[1][7:0]=FF.
- Errors: awburst=10 len=1 → 2 beats accepted, no writes, bresp=10. addr=0x1000 (idx 1024) len=0 → bresp=11, memory unchanged.
- Backpressure + reset: bready held low 5 cycles → bvalid/bid/bresp stable and awready=0 throughout. Assert aresetn=0 mid-burst (after 2 of 4 beats) → outputs 0 immediately, first 2 words written, no B response.
